// File: rtl/uart_transmitter.sv
// uart_transmitter: transmit half of the UART. Serialises one byte at a time
// onto SOut as an async frame: start bit, 8 data bits LSB-first, stop bit.
// A byte is accepted on a rising edge where DataInValid && DataInReady.
// DataInReady and SOut are both registered.
//
// Optional feature macro: UART_TX_PARITY_EN
//   When defined, an even-parity bit follows the data bits (8E1 framing).
//   When undefined, the frame is plain 8N1 and no parity logic exists.
module uart_transmitter #(
  parameter int CLOCK_FREQ = 33_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic       SOut
);

  // Clocks per serial bit (truncating division) and the counter width for it.
  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
`ifdef UART_TX_PARITY_EN
  logic             parity;
`endif

  // Bit-end strobe: the current symbol has been held for its full duration.
  logic bit_end;
  assign bit_end = (clk_cnt == CNT_LAST);

  // Framing FSM; SOut is registered one clock ahead of each symbol so the
  // start bit is on the line right after the accepting edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      SOut        <= 1'b1;
      DataInReady <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (DataInValid && DataInReady) begin
            shift       <= DataIn;
`ifdef UART_TX_PARITY_EN
            // Parity comes from the captured byte, never from DataIn later.
            parity      <= ^DataIn;
`endif
            bit_cnt     <= '0;
            clk_cnt     <= '0;
            SOut        <= 1'b0;
            DataInReady <= 1'b0;
            state       <= START;
          end
        end

        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            SOut    <= shift[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              SOut  <= parity;
              state <= PARITY;
`else
              SOut  <= 1'b1;
              state <= STOP;
`endif
            end else begin
              // Next data bit is the one about to shift into position 0.
              SOut <= shift[1];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            SOut    <= 1'b1;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            clk_cnt     <= '0;
            DataInReady <= 1'b1;
            state       <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end

        default: begin
          clk_cnt     <= '0;
          SOut        <= 1'b1;
          DataInReady <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
